btn_event_decoder: RTL and testbench

//  Input-side counterpart to the LED/7-segment FSM output path. Conditions four raw

---
 rtl/btn_event_decoder.sv | 180 ++++++++++++++++++
 tb/tb_btn_event_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
//==============================================================================
// Module      : btn_event_decoder
// Description : Conditions four raw push-buttons (2-FF synchroniser plus a
//               per-button debounce counter) and turns each debounced press
//               into a 3-bit event code {long, idx[1:0]}. Events are held in a
//               1-entry valid/ready buffer. A sticky overflow flag records any
//               event that had to be dropped.
//               Optional feature macro: LONG_PRESS_EN (adds long-press events).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module btn_event_decoder #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
    parameter logic [23:0] LONG_CYCLES     = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_in,
    output logic [3:0] btn_level,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    input  logic       evt_ready,
    output logic       overflow
);

    localparam logic [15:0] c_deb_last = DEBOUNCE_CYCLES - 16'd1;

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_level;
    logic [3:0]  r_level_d;
    logic [15:0] r_deb_cnt [4];

    logic        r_valid;
    logic [2:0]  r_code;
    logic        r_overflow;

    logic [3:0]  w_press;
    logic [3:0]  w_long;
    logic        w_req_any;
    logic [3:0]  w_req_cnt;
    logic [2:0]  w_win_code;
    logic        w_pop;
    logic        w_can_load;

    // Two-stage synchroniser for the asynchronous button inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a new level must persist DEBOUNCE_CYCLES cycles before it is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level   <= 4'b0000;
            r_level_d <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_deb_cnt[i] <= 16'd0;
            end
        end else begin
            r_level_d <= r_level;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_deb_cnt[i] <= 16'd0;
                end else if (r_deb_cnt[i] == c_deb_last) begin
                    r_level[i]   <= r_sync2[i];
                    r_deb_cnt[i] <= 16'd0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 16'd1;
                end
            end
        end
    end

    // A press is a debounced 0->1 transition; releases produce nothing
    assign w_press = r_level & ~r_level_d;

`ifdef LONG_PRESS_EN
    localparam logic [23:0] c_long_last = LONG_CYCLES - 24'd1;

    logic [23:0] r_hold_cnt [4];
    logic [3:0]  r_hold_done;

    // Hold counters: count while pressed, fire once per hold, rearm on release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_done <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_hold_cnt[i] <= 24'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!r_level[i]) begin
                    r_hold_cnt[i]  <= 24'd0;
                    r_hold_done[i] <= 1'b0;
                end else if (!r_hold_done[i]) begin
                    if (r_hold_cnt[i] == c_long_last) begin
                        r_hold_done[i] <= 1'b1;
                    end else begin
                        r_hold_cnt[i] <= r_hold_cnt[i] + 24'd1;
                    end
                end
            end
        end
    end

    // Long-press request raised on the single cycle the hold count hits its target
    always_comb begin
        w_long = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_long[i] = r_level[i] && !r_hold_done[i] && (r_hold_cnt[i] == c_long_last);
        end
    end

    assign evt_code = r_code;
`else
    logic w_unused_long;

    // Long-press hardware is absent; the long bit of the code is a constant 0
    assign w_long        = 4'b0000;
    assign w_unused_long = ^{LONG_CYCLES, r_code[2]};
    assign evt_code      = {1'b0, r_code[1:0]};
`endif

    // Arbitration: short presses beat long presses, then lowest index wins
    always_comb begin
        w_win_code = 3'b000;
        w_req_cnt  = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_long[i]) begin
                w_win_code = {1'b1, 2'(i)};
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (w_press[i]) begin
                w_win_code = {1'b0, 2'(i)};
            end
        end
        for (int i = 0; i < 4; i++) begin
            w_req_cnt = w_req_cnt + {3'b000, w_press[i]} + {3'b000, w_long[i]};
        end
    end

    assign w_req_any  = (w_req_cnt != 4'd0);
    assign w_pop      = r_valid & evt_ready;
    assign w_can_load = ~r_valid | w_pop;

    // Single-entry event buffer with pass-through on pop and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_code     <= 3'b000;
            r_overflow <= 1'b0;
        end else begin
            if (w_req_any && w_can_load) begin
                r_valid <= 1'b1;
                r_code  <= w_win_code;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            // Losers of arbitration, or a winner that finds the buffer full, are lost
            if ((w_req_cnt > 4'd1) || (w_req_any && !w_can_load)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign btn_level = r_level;
    assign evt_valid = r_valid;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_btn_event_decoder.sv
//==============================================================================
// Module      : tb_btn_event_decoder
// Description : Self-checking bench for btn_event_decoder. Expected event codes
//               are queued by the stimulus process; a monitor pops and compares
//               them on every accepted event. Honours LONG_PRESS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_btn_event_decoder;

    localparam logic [15:0] DEB  = 16'd4;
    localparam logic [23:0] LONG = 24'd20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;
    logic       overflow;

    logic [2:0] exp_q [$];
    int         n_pass  = 0;
    int         n_total = 0;

    btn_event_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        edges(1);
        rst_n = 1'b1;
    endtask

    // Monitor: every accepted event must match the oldest expected code
    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_event: got code %0b, expected none", evt_code);
            end else begin
                check("evt_code", 32'(evt_code), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic glitch_seen;
        rst_n     = 1'b0;
        btn_in    = 4'b0000;
        evt_ready = 1'b1;
        edges(2);
        check("reset_outputs", 32'({btn_level, evt_valid, evt_code, overflow}), 32'd0);
        rst_n = 1'b1;

        // 1: single press on button 1, check exact latency
        btn_in = 4'b0010;
        edges(5);
        check("t1_level_pre", 32'(btn_level), 32'h0);
        edges(1);
        check("t1_level", 32'(btn_level), 32'h2);
        check("t1_valid_pre", 32'(evt_valid), 32'd0);
        exp_q.push_back(3'b001);
        edges(1);
        check("t1_valid", 32'(evt_valid), 32'd1);
        check("t1_code", 32'(evt_code), 32'b001);
        edges(1);
        check("t1_valid_post", 32'(evt_valid), 32'd0);
        check("t1_overflow", 32'(overflow), 32'd0);
        btn_in = 4'b0000;
        edges(10);
        check("t1_release", 32'(btn_level), 32'h0);

        // 2: two 3-cycle glitches on button 2 never get through
        glitch_seen = 1'b0;
        btn_in = 4'b0100;
        for (int k = 0; k < 3; k++) begin edges(1); if (btn_level != 4'h0) glitch_seen = 1'b1; end
        btn_in = 4'b0000;
        for (int k = 0; k < 2; k++) begin edges(1); if (btn_level != 4'h0) glitch_seen = 1'b1; end
        btn_in = 4'b0100;
        for (int k = 0; k < 3; k++) begin edges(1); if (btn_level != 4'h0) glitch_seen = 1'b1; end
        btn_in = 4'b0000;
        for (int k = 0; k < 12; k++) begin edges(1); if (btn_level != 4'h0) glitch_seen = 1'b1; end
        check("t2_glitch_level", 32'(glitch_seen), 32'd0);
        check("t2_no_event", 32'(evt_valid), 32'd0);

        // 3: simultaneous presses on buttons 0 and 3
        btn_in = 4'b1001;
        exp_q.push_back(3'b000);
        edges(7);
        check("t3_valid", 32'(evt_valid), 32'd1);
        check("t3_code", 32'(evt_code), 32'b000);
        edges(1);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_single_event", 32'(evt_valid), 32'd0);
        btn_in = 4'b0000;
        edges(10);

        // 4: full buffer drops the second press and holds the first code
        do_reset();
        check("t4_overflow_cleared", 32'(overflow), 32'd0);
        evt_ready = 1'b0;
        btn_in    = 4'b0010;
        edges(8);
        check("t4_valid", 32'(evt_valid), 32'd1);
        check("t4_code", 32'(evt_code), 32'b001);
        btn_in = 4'b0110;
        edges(8);
        check("t4_code_hold", 32'(evt_code), 32'b001);
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_valid_hold", 32'(evt_valid), 32'd1);
        exp_q.push_back(3'b001);
        evt_ready = 1'b1;
        edges(1);
        check("t4_popped", 32'(evt_valid), 32'd0);
        btn_in = 4'b0000;
        edges(10);

        // 5: reset with a pending event while button 3 is held
        do_reset();
        evt_ready = 1'b0;
        btn_in    = 4'b1000;
        edges(8);
        check("t5_pending", 32'({evt_valid, evt_code}), 32'b1011);
        rst_n = 1'b0;
        edges(1);
        check("t5_reset_outputs", 32'({btn_level, evt_valid, evt_code, overflow}), 32'd0);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        exp_q.push_back(3'b011);
        edges(6);
        check("t5_valid_early", 32'(evt_valid), 32'd0);
        edges(1);
        check("t5_reemit", 32'({evt_valid, evt_code}), 32'b1011);
        btn_in = 4'b0000;
        edges(10);

        // 6: hold button 0 for 40 cycles
        do_reset();
        btn_in = 4'b0001;
        exp_q.push_back(3'b000);
`ifdef LONG_PRESS_EN
        exp_q.push_back(3'b100);
`endif
        edges(7);
        check("t6_short", 32'({evt_valid, evt_code}), 32'b1000);
`ifdef LONG_PRESS_EN
        edges(18);
        check("t6_long_pre", 32'(evt_valid), 32'd0);
        edges(1);
        check("t6_long", 32'({evt_valid, evt_code}), 32'b1100);
        edges(14);
`else
        edges(33);
`endif
        btn_in = 4'b0000;
        edges(12);
        check("t6_overflow", 32'(overflow), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
